ss: RTL and testbench
=====================

// Module: ss
// PURPOSE
//  Streaming matrix-product reducer. Accepts an n x n matrix W, then an n x n matrix X (n = 2 or 4),
//  serially on one 16-bit bus. Computes Y = W*X and emits the 2n-1 anti-diagonal sums
//  S[k] = sum over i+j=k of Y[i][j], for k = 0..2n-2, serially on a 40-bit bus.
//  Standalone compute leaf; the upstream block is a stream source, the downstream block is a result sink.
// PARAMETERS
//  none (data width 16, result width 40, max n = 4 are fixed)
// PORTS
//  clk          in   1   single clock; all logic on rising edge
//  rst_n        in   1   synchronous, active-high reset (reset when rst_n==1 at a rising clk edge)
//  in_valid     in   1   qualifies matrix/matrix_size for this cycle
//  matrix       in   16  signed two's-complement element; W then X, row-major
//  matrix_size  in   1   0: n=2; 1: n=4. Sampled on the first in_valid beat of a job only
//  out_valid    out  1   high while out_value carries a valid S[k]
//  out_value    out  40  signed S[k], k in increasing order
// BEHAVIOUR
//  - Reset: all state cleared; FSM=IDLE; out_valid=0; out_value=0; partial job discarded.
//  - FSM: IDLE -> LOAD_W -> LOAD_X -> REDUCE -> OUTPUT -> IDLE.
//    IDLE: first in_valid beat latches n from matrix_size, stores W[0][0], goes to LOAD_W.
//    LOAD_W: stores beats until n*n W elements are held, then LOAD_X.
//    LOAD_X: each beat X[k][j] adds W[i][k]*X[k][j] into Y[i][j] for every i (n multipliers,
//    Y cleared at job start). After the n*n-th X beat, go to REDUCE.
//    REDUCE: one cycle; forms all S[k] into registers. Then OUTPUT.
//    OUTPUT: 2n-1 cycles, one S[k] per cycle with out_valid=1, k=0 first; then IDLE.
//  - Beat counting: only cycles with in_valid=1 count; gaps (in_valid=0) within LOAD_W/LOAD_X are
//    legal and simply stall. matrix_size changes after the first beat are ignored.
//  - Latency: last X beat sampled at edge e -> out_valid=1 on the cycles after edges e+2 .. e+2n
//    (i.e. first S[0] visible 2 cycles after last beat); out_valid is contiguous, no gaps.
//  - in_valid during REDUCE/OUTPUT is ignored (beats dropped); a new job may start the cycle after
//    OUTPUT ends (FSM back in IDLE).
//  - Arithmetic: 16x16 signed products (32b), sign-extended and accumulated at 40b; n<=4 products
//    per Y and <=4 Y per S keep magnitude < 2^36, so no overflow handling is needed.
//  - out_value = 0 whenever out_valid = 0.
//  - Reset asserted mid-load or mid-output: aborts immediately; out_valid drops the next edge;
//    no further output of the aborted job.
// TESTING
//  1. Reset: rst_n=1 for 2 cycles -> out_valid=0, out_value=0; no output without input.
//  2. n=2: W=1,2,3,4 X=5,6,7,8 contiguous -> out_valid 3 cycles, out_value 19, 65, 50.
//  3. n=4: W=X=1..16 contiguous, right after test 2 -> 7 values 90, 302, 652, 1156, 1162, 982, 600.
//  4. n=2 with in_valid gaps between beats, same data as test 2 -> identical 19, 65, 50;
//     first output 2 cycles after last beat.
//  5. Signed: n=2, W=-1,0,0,-1 X=32767,-32768,1,2 -> -32767, 32767, -2.
//  6. Reset mid-LOAD_X of an n=4 job, then run test 2 -> only 19, 65, 50 appear.

Source files
------------

// File: rtl/ss.sv
// ---------------------------------------------------------------------------
// ss : streaming matrix-product reducer
//
// Receives an n x n matrix W and then an n x n matrix X (n = 2 or 4), one
// signed 16-bit element per in_valid beat, row-major. Y = W*X is accumulated
// while X streams in. The 2n-1 anti-diagonal sums S[k] = sum(Y[i][j], i+j=k)
// are then emitted one per cycle, S[0] first.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst_n        in   1   synchronous reset, active HIGH (resets when 1)
//   in_valid     in   1   qualifies matrix / matrix_size
//   matrix       in   16  signed element (W then X, row-major)
//   matrix_size  in   1   0: n=2, 1: n=4; sampled on a job's first beat only
//   out_valid    out  1   out_value carries a valid S[k]
//   out_value    out  40  signed S[k]; zero when out_valid is low
// ---------------------------------------------------------------------------
module ss (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic signed [15:0] matrix,
  input  logic               matrix_size,
  output logic               out_valid,
  output logic signed [39:0] out_value
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_X,
    REDUCE,
    OUTPUT
  } state_t;

  typedef logic signed [15:0] elem_t;
  typedef logic signed [39:0] acc_t;

  state_t      state_q, state_d;
  logic        n4_q, n4_d;          // 1: n=4, 0: n=2
  logic [3:0]  cnt_q, cnt_d;        // beat index within the current matrix
  logic [2:0]  idx_q, idx_d;        // S[k] index during OUTPUT
  elem_t       w_q [4][4];
  elem_t       w_d [4][4];
  acc_t        y_q [4][4];
  acc_t        y_d [4][4];
  acc_t        s_q [7];
  acc_t        s_d [7];
  logic        out_valid_q, out_valid_d;
  acc_t        out_value_q, out_value_d;

  logic [1:0]         row, col;
  logic [3:0]         last_beat;
  logic [2:0]         last_out;
  logic signed [31:0] prod [4];
  acc_t               diag [7];

  // Beat index -> (row, col) depends on n: n=2 uses cnt[1]/cnt[0],
  // n=4 uses cnt[3:2]/cnt[1:0].
  always_comb begin
    row       = n4_q ? cnt_q[3:2] : {1'b0, cnt_q[1]};
    col       = n4_q ? cnt_q[1:0] : {1'b0, cnt_q[0]};
    last_beat = n4_q ? 4'd15 : 4'd3;
    last_out  = n4_q ? 3'd6  : 3'd2;
  end

  // One multiplier per Y row: beat X[row][col] contributes W[i][row]*X[row][col]
  // to Y[i][col]. Both operands are signed and the 32-bit target widens them
  // before the multiply, so the product is exact.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      prod[i] = w_q[i][row] * matrix;
    end
  end

  // Anti-diagonal sums over the whole 4x4 Y array. For n=2 the unused Y
  // entries stay at zero (cleared at job start, never accumulated).
  always_comb begin
    for (int k = 0; k < 7; k++) begin
      diag[k] = '0;
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          if (i + j == k) diag[k] = diag[k] + y_q[i][j];
        end
      end
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    n4_d        = n4_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    w_d         = w_q;
    y_d         = y_q;
    s_d         = s_q;
    out_valid_d = 1'b0;
    out_value_d = '0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          n4_d      = matrix_size;
          w_d[0][0] = matrix;
          y_d       = '{default: '0};
          cnt_d     = 4'd1;
          state_d   = LOAD_W;
        end
      end

      LOAD_W: begin
        if (in_valid) begin
          w_d[row][col] = matrix;
          if (cnt_q == last_beat) begin
            cnt_d   = '0;
            state_d = LOAD_X;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      LOAD_X: begin
        if (in_valid) begin
          for (int i = 0; i < 4; i++) begin
            if (n4_q || i < 2) begin
              y_d[i][col] = y_q[i][col] + acc_t'(prod[i]);
            end
          end
          if (cnt_q == last_beat) begin
            cnt_d   = '0;
            state_d = REDUCE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      REDUCE: begin
        s_d     = diag;
        idx_d   = '0;
        state_d = OUTPUT;
      end

      OUTPUT: begin
        out_valid_d = 1'b1;
        out_value_d = s_q[idx_q];
        if (idx_q == last_out) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from before this edge.
    if (rst_n) begin
      state_q     <= IDLE;
      n4_q        <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      // NOTE: the operand/accumulator arrays are small flop arrays, not RAM,
      // so clearing them on reset is cheap and leaves no stale job data.
      w_q         <= '{default: '0};
      y_q         <= '{default: '0};
      s_q         <= '{default: '0};
      out_valid_q <= 1'b0;
      out_value_q <= '0;
    end else begin
      state_q     <= state_d;
      n4_q        <= n4_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      w_q         <= w_d;
      y_q         <= y_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_value = out_value_q;

endmodule

// File: tb/tb_ss.sv
// ---------------------------------------------------------------------------
// tb_ss : directed self-checking bench for ss.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ss;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [15:0] matrix = '0;
  logic               matrix_size = 1'b0;
  logic               out_valid;
  logic signed [39:0] out_value;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [15:0] w_v [16];
  logic signed [15:0] x_v [16];
  logic signed [39:0] exp_v [7];

  always #5 clk = ~clk;

  ss dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .matrix      (matrix),
    .matrix_size (matrix_size),
    .out_valid   (out_valid),
    .out_value   (out_value)
  );

  task automatic check(input string tag, input logic signed [39:0] obs,
                       input logic signed [39:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic beat(input logic signed [15:0] v, input logic sz);
    @(negedge clk);
    in_valid    = 1'b1;
    matrix      = v;
    matrix_size = sz;
  endtask

  // Drive W then X. With gap=1 an idle cycle precedes every beat but the
  // first, and matrix_size is flipped after the first beat (must be ignored).
  task automatic send_job(input int n, input logic sz, input bit gap);
    for (int i = 0; i < 2 * n * n; i++) begin
      if (gap && i > 0) idle_cycle();
      beat((i < n * n) ? w_v[i] : x_v[i - n * n],
           (gap && i > 0) ? ~sz : sz);
    end
  endtask

  // Called right after the last X beat was set up: the next posedge is e.
  task automatic expect_job(input string tag, input int n);
    idle_cycle();                                       // after edge e
    @(negedge clk);                                     // after edge e+1
    check($sformatf("%s_early_valid", tag), {39'b0, out_valid}, 40'sd0);
    for (int k = 0; k < 2 * n - 1; k++) begin
      @(negedge clk);                                   // after edge e+2+k
      check($sformatf("%s_valid%0d", tag, k), {39'b0, out_valid}, 40'sd1);
      check($sformatf("%s_S%0d", tag, k), out_value, exp_v[k]);
    end
    @(negedge clk);
    check($sformatf("%s_end_valid", tag), {39'b0, out_valid}, 40'sd0);
    check($sformatf("%s_end_value", tag), out_value, 40'sd0);
  endtask

  task automatic load_test2();
    w_v[0] = 1; w_v[1] = 2; w_v[2] = 3; w_v[3] = 4;
    x_v[0] = 5; x_v[1] = 6; x_v[2] = 7; x_v[3] = 8;
    exp_v = '{19, 65, 50, 0, 0, 0, 0};
  endtask

  initial begin
    // 1. Reset held for two cycles, then no output without input.
    repeat (2) @(negedge clk);
    check("reset_valid", {39'b0, out_valid}, 40'sd0);
    check("reset_value", out_value, 40'sd0);
    rst_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("idle_valid", {39'b0, out_valid}, 40'sd0);
    end

    // 2. n=2 contiguous.
    load_test2();
    send_job(2, 1'b0, 1'b0);
    expect_job("t2", 2);

    // 3. n=4, W = X = 1..16, straight after test 2.
    for (int i = 0; i < 16; i++) begin
      w_v[i] = 16'(i + 1);
      x_v[i] = 16'(i + 1);
    end
    exp_v = '{90, 302, 652, 1156, 1162, 982, 600};
    send_job(4, 1'b1, 1'b0);
    expect_job("t3", 4);

    // 4. n=2 with gaps and a toggling matrix_size after the first beat.
    load_test2();
    send_job(2, 1'b0, 1'b1);
    expect_job("t4", 2);

    // 5. Signed extremes.
    w_v[0] = -1; w_v[1] = 0; w_v[2] = 0; w_v[3] = -1;
    x_v[0] = 32767; x_v[1] = -32768; x_v[2] = 1; x_v[3] = 2;
    exp_v = '{-32767, 32767, -2, 0, 0, 0, 0};
    send_job(2, 1'b0, 1'b0);
    expect_job("t5", 2);

    // Reset during OUTPUT: out_valid must drop at the next edge and stay low.
    load_test2();
    send_job(2, 1'b0, 1'b0);
    idle_cycle();
    begin
      int wait_cnt = 0;
      while (!out_valid && wait_cnt < 10) begin
        @(negedge clk);
        wait_cnt++;
      end
      check("midout_seen_valid", {39'b0, out_valid}, 40'sd1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("midout_rst_valid", {39'b0, out_valid}, 40'sd0);
    check("midout_rst_value", out_value, 40'sd0);
    rst_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("midout_after_valid", {39'b0, out_valid}, 40'sd0);
    end

    // 6. Reset mid-LOAD_X of an n=4 job, then test 2 again.
    for (int i = 0; i < 16; i++) begin
      beat(16'(i + 3), 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      beat(16'(i + 7), 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t6_abort_valid", {39'b0, out_valid}, 40'sd0);
    end
    load_test2();
    send_job(2, 1'b0, 1'b0);
    expect_job("t6", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
